// File: rtl/wa_pkg.sv
// Shared defaults, derived widths and bank-state encoding for the tile streamer
// and the workload allocator.
package wa_pkg;

  localparam int unsigned DEF_TILE_WIDTH = 16;
  localparam int unsigned DEF_IMG_WIDTH  = 640;
  localparam int unsigned DEF_IMG_HEIGHT = 480;
  localparam int unsigned PIXEL_W        = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_BANK_AW = cnt_width(DEF_TILE_WIDTH * DEF_IMG_WIDTH);
  localparam int unsigned DEF_COL_W   = cnt_width(DEF_IMG_WIDTH);
  localparam int unsigned DEF_LINE_W  = cnt_width(DEF_TILE_WIDTH);

endpackage

// File: rtl/tile_streamer_if.sv
// Raster-in / tiled-out stream bundle between the environment and tile_streamer.
interface tile_streamer_if;

  logic [wa_pkg::PIXEL_W-1:0] iData;
  logic                       iValid;
  logic                       oReady;
  logic [wa_pkg::PIXEL_W-1:0] oData;
  logic                       oValid;
  logic                       iReady;
  logic                       oTileLast;
  logic                       oFrameLast;

  modport master (
    output iData, iValid, iReady,
    input  oReady, oData, oValid, oTileLast, oFrameLast
  );

  modport slave (
    input  iData, iValid, iReady,
    output oReady, oData, oValid, oTileLast, oFrameLast
  );

endinterface

// File: rtl/stripe_bank_ram.sv
// One stripe bank: simple dual-port RAM, write port plus registered read port
// whose output holds while re is low.
module stripe_bank_ram
  import wa_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_TILE_WIDTH * DEF_IMG_WIDTH,
  parameter int unsigned AW    = DEF_BANK_AW
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               re,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tile_streamer.sv
// Raster-to-tile reorder buffer: two stripe banks ping-pong between a raster
// writer and a tile-order reader with a one-deep registered output.
module tile_streamer
  import wa_pkg::*;
#(
  parameter int unsigned TILE_WIDTH = DEF_TILE_WIDTH,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input logic            iClk,
  input logic            iRst,
  tile_streamer_if.slave bus
);

  localparam int unsigned TILES    = IMG_WIDTH / TILE_WIDTH;
  localparam int unsigned STRIPES  = IMG_HEIGHT / TILE_WIDTH;
  localparam int unsigned DEPTH    = TILE_WIDTH * IMG_WIDTH;
  localparam int unsigned AW       = cnt_width(DEPTH);
  localparam int unsigned TW_W     = cnt_width(TILE_WIDTH);
  localparam int unsigned COL_W    = cnt_width(IMG_WIDTH);
  localparam int unsigned TILE_W   = cnt_width(TILES);
  localparam int unsigned STRIPE_W = cnt_width(STRIPES);

  localparam logic [TW_W-1:0]     TW_LAST     = TW_W'(TILE_WIDTH - 1);
  localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(IMG_WIDTH - 1);
  localparam logic [TILE_W-1:0]   TILE_LAST   = TILE_W'(TILES - 1);
  localparam logic [STRIPE_W-1:0] STRIPE_LAST = STRIPE_W'(STRIPES - 1);

  bank_state_e         bank_st [2];
  logic                ready_en;
  logic                wr_ptr, rd_ptr;
  logic [TW_W-1:0]     wr_line, rd_row, rd_col;
  logic [COL_W-1:0]    wr_col;
  logic [TILE_W-1:0]   rd_tile;
  logic [STRIPE_W-1:0] rd_stripe;
  logic                out_valid, out_bank, out_tile_last, out_frame_last, out_bank_last;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic [PIXEL_W-1:0]  rd_data_a, rd_data_b;
  logic                accept, wr_stripe_end, rd_avail, issue, rd_tile_end, rd_bank_end;

  assign bus.oReady = ready_en &&
                      (bank_st[wr_ptr] == BANK_EMPTY || bank_st[wr_ptr] == BANK_FILLING);
  assign accept        = bus.iValid && bus.oReady;
  assign wr_stripe_end = (wr_line == TW_LAST) && (wr_col == COL_LAST);
  assign wr_addr       = AW'(wr_line) * AW'(IMG_WIDTH) + AW'(wr_col);

  // A read is issued whenever the output register is free or emptying this cycle.
  assign rd_avail    = (bank_st[rd_ptr] == BANK_FULL) || (bank_st[rd_ptr] == BANK_DRAINING);
  assign issue       = rd_avail && (!out_valid || bus.iReady);
  assign rd_tile_end = (rd_row == TW_LAST) && (rd_col == TW_LAST);
  assign rd_bank_end = rd_tile_end && (rd_tile == TILE_LAST);
  assign rd_addr     = AW'(rd_row) * AW'(IMG_WIDTH) + AW'(rd_tile) * AW'(TILE_WIDTH) + AW'(rd_col);

  assign bus.oValid     = out_valid;
  assign bus.oTileLast  = out_tile_last;
  assign bus.oFrameLast = out_frame_last;
  assign bus.oData      = out_valid ? (out_bank ? rd_data_b : rd_data_a) : '0;

  stripe_bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank_a (
    .clk     (iClk),
    .we      (accept && !wr_ptr),
    .wr_addr (wr_addr),
    .wr_data (bus.iData),
    .re      (issue && !rd_ptr),
    .rd_addr (rd_addr),
    .rd_data (rd_data_a)
  );

  stripe_bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank_b (
    .clk     (iClk),
    .we      (accept && wr_ptr),
    .wr_addr (wr_addr),
    .wr_data (bus.iData),
    .re      (issue && rd_ptr),
    .rd_addr (rd_addr),
    .rd_data (rd_data_b)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      bank_st[0]     <= BANK_EMPTY;
      bank_st[1]     <= BANK_EMPTY;
      ready_en       <= 1'b0;
      wr_ptr         <= 1'b0;
      wr_line        <= '0;
      wr_col         <= '0;
      rd_ptr         <= 1'b0;
      rd_tile        <= '0;
      rd_row         <= '0;
      rd_col         <= '0;
      rd_stripe      <= '0;
      out_valid      <= 1'b0;
      out_bank       <= 1'b0;
      out_tile_last  <= 1'b0;
      out_frame_last <= 1'b0;
      out_bank_last  <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (accept) begin
        if (wr_stripe_end) begin
          bank_st[wr_ptr] <= BANK_FULL;
          wr_ptr          <= ~wr_ptr;
        end else if (bank_st[wr_ptr] == BANK_EMPTY) begin
          bank_st[wr_ptr] <= BANK_FILLING;
        end
        if (wr_col == COL_LAST) begin
          wr_col  <= '0;
          wr_line <= (wr_line == TW_LAST) ? '0 : wr_line + TW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end

      // Write, issue and release always touch different banks, so these never collide.
      if (out_valid && bus.iReady && out_bank_last) begin
        bank_st[out_bank] <= BANK_EMPTY;
      end

      if (issue) begin
        if (bank_st[rd_ptr] == BANK_FULL) begin
          bank_st[rd_ptr] <= BANK_DRAINING;
        end
        out_valid      <= 1'b1;
        out_bank       <= rd_ptr;
        out_tile_last  <= rd_tile_end;
        out_bank_last  <= rd_bank_end;
        out_frame_last <= rd_bank_end && (rd_stripe == STRIPE_LAST);
        if (rd_col == TW_LAST) begin
          rd_col <= '0;
          if (rd_row == TW_LAST) begin
            rd_row <= '0;
            if (rd_tile == TILE_LAST) begin
              rd_tile   <= '0;
              rd_ptr    <= ~rd_ptr;
              rd_stripe <= (rd_stripe == STRIPE_LAST) ? '0 : rd_stripe + STRIPE_W'(1);
            end else begin
              rd_tile <= rd_tile + TILE_W'(1);
            end
          end else begin
            rd_row <= rd_row + TW_W'(1);
          end
        end else begin
          rd_col <= rd_col + TW_W'(1);
        end
      end else if (bus.iReady) begin
        out_valid      <= 1'b0;
        out_tile_last  <= 1'b0;
        out_frame_last <= 1'b0;
        out_bank_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_streamer.sv
// Bench for tile_streamer with 4x4 tiles over an 8x8 image; a reference model
// predicts the tiled order and output availability from accepted stripe counts.
module tb_tile_streamer;

  localparam int TW        = 4;
  localparam int IW        = 8;
  localparam int IH        = 8;
  localparam int TILE_PIX  = TW * TW;
  localparam int STRIPE_PX = TW * IW;
  localparam int FRAME_PX  = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tile_streamer_if bus ();

  tile_streamer #(
    .TILE_WIDTH (TW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int pidx     = 0;

  int acc_cnt = 0, out_cnt = 0, acc_h1 = 0, acc_h2 = 0;
  int tcnt = 0, fcnt = 0;
  bit stalled = 1'b0;
  int held_data, held_tl, held_fl;
  int obs_q [$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expected value of the k-th tiled output pixel, from the tiling rules alone.
  function automatic int model_pixel(input int k);
    int p, s, q, t, w, r, c;
    p = k % FRAME_PX;
    s = p / STRIPE_PX;
    q = p % STRIPE_PX;
    t = q / TILE_PIX;
    w = q % TILE_PIX;
    r = w / TW;
    c = w % TW;
    return ((s * TW + r) * IW + t * TW + c) % 256;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0; out_cnt = 0; acc_h1 = 0; acc_h2 = 0;
      tcnt = 0; fcnt = 0; stalled = 1'b0;
      obs_q.delete();
    end else begin
      // A pixel is visible two cycles after its stripe completes, and stays until taken.
      check("valid", int'(bus.oValid), int'(out_cnt < STRIPE_PX * (acc_h2 / STRIPE_PX)));
      if (stalled) begin
        check("hold_data", int'(bus.oData), held_data);
        check("hold_tile_last", int'(bus.oTileLast), held_tl);
        check("hold_frame_last", int'(bus.oFrameLast), held_fl);
      end
      if (bus.oValid && bus.iReady) begin
        check("data", int'(bus.oData), model_pixel(out_cnt));
        check("tile_last", int'(bus.oTileLast), int'((out_cnt % TILE_PIX) == TILE_PIX - 1));
        check("frame_last", int'(bus.oFrameLast), int'((out_cnt % FRAME_PX) == FRAME_PX - 1));
        obs_q.push_back(int'(bus.oData));
        tcnt += int'(bus.oTileLast);
        fcnt += int'(bus.oFrameLast);
        out_cnt++;
        stalled = 1'b0;
      end else if (bus.oValid) begin
        stalled   = 1'b1;
        held_data = int'(bus.oData);
        held_tl   = int'(bus.oTileLast);
        held_fl   = int'(bus.oFrameLast);
      end else begin
        stalled = 1'b0;
      end
      if (bus.iValid && bus.oReady) acc_cnt++;
      acc_h2 = acc_h1;
      acc_h1 = acc_cnt;
    end
  end

  task automatic set_ready(input int mode);
    case (mode)
      0:       bus.iReady = 1'b1;
      1:       bus.iReady = 1'b0;
      default: bus.iReady = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic stream(input int n, input int mode);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 3000) begin
      @(posedge clk); #1;
      bus.iValid = 1'b1;
      bus.iData  = 8'(pidx);
      set_ready(mode);
      @(negedge clk);
      if (bus.oReady) begin
        sent++;
        pidx = (pidx + 1) % FRAME_PX;
      end
      guard++;
    end
    check("stream_budget", sent, n);
  endtask

  task automatic drain(input int target, input int mode);
    int guard = 0;
    while (out_cnt < target && guard < 3000) begin
      @(posedge clk); #1;
      bus.iValid = 1'b0;
      set_ready(mode);
      @(negedge clk);
      guard++;
    end
    check("drain_budget", out_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iData  = '0;
    pidx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(bus.oValid), 0);
    check("rst_data", int'(bus.oData), 0);
    check("rst_tile_last", int'(bus.oTileLast), 0);
    check("rst_frame_last", int'(bus.oFrameLast), 0);
    check("rst_ready", int'(bus.oReady), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", int'(bus.oReady), 1);
  endtask

  initial begin
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iData  = '0;

    // Single frame, downstream always ready; pin latency and the tiled order.
    do_reset();
    stream(STRIPE_PX, 0);
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    @(negedge clk);
    check("lat_n1_valid", int'(bus.oValid), 0);
    @(negedge clk);
    check("lat_n2_valid", int'(bus.oValid), 1);
    check("lat_n2_data", int'(bus.oData), 0);
    stream(STRIPE_PX, 0);
    drain(FRAME_PX, 0);
    check("f1_count", obs_q.size(), 64);
    check("f1_px0", obs_q[0], 0);
    check("f1_px3", obs_q[3], 3);
    check("f1_px4", obs_q[4], 8);
    check("f1_px8", obs_q[8], 16);
    check("f1_px15", obs_q[15], 27);
    check("f1_px16", obs_q[16], 4);
    check("f1_px20", obs_q[20], 12);
    check("f1_px32", obs_q[32], 32);
    check("f1_px63", obs_q[63], 63);
    check("f1_tile_lasts", tcnt, 4);
    check("f1_frame_lasts", fcnt, 1);

    // Backpressure: both banks fill while downstream is stalled.
    do_reset();
    stream(FRAME_PX, 1);
    @(posedge clk); #1;
    bus.iValid = 1'b1;
    bus.iData  = 8'(pidx);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", int'(bus.oReady), 0);
    end
    check("bp_accepted", acc_cnt, FRAME_PX);
    drain(FRAME_PX, 0);
    check("bp_first", obs_q[0], 0);
    check("bp_last", obs_q[63], 63);

    // Random downstream stalls over two frames.
    do_reset();
    stream(2 * FRAME_PX, 2);
    drain(2 * FRAME_PX, 2);
    check("rand_frame_lasts", fcnt, 2);
    check("rand_tile_lasts", tcnt, 8);

    // Reset in the middle of a stripe discards it.
    do_reset();
    stream(20, 0);
    do_reset();
    bus.iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", int'(bus.oValid), 0);
    end
    stream(FRAME_PX, 0);
    drain(FRAME_PX, 0);
    check("midrst_px0", obs_q[0], 0);
    check("midrst_px1", obs_q[1], 1);
    check("midrst_frame_lasts", fcnt, 1);

    // Back-to-back frames with everything held ready.
    do_reset();
    stream(3 * FRAME_PX, 0);
    drain(3 * FRAME_PX, 0);
    check("b2b_frame_lasts", fcnt, 3);
    check("b2b_px64", obs_q[64], 0);
    check("b2b_px191", obs_q[191], 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    n_fails++;
    $display("FAIL watchdog: simulation time limit reached, out_cnt %0d", out_cnt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end

endmodule
